// File: rtl/apu_pkg.sv
// apu_pkg: shared state encoding and default widths for the APU frequency sweep unit.
package apu_pkg;

    localparam int DEF_FREQ_W   = 11;
    localparam int DEF_SHIFT_W  = 3;
    localparam int DEF_PERIOD_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_SUM    = 2'd2,
        ST_COMMIT = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/sweep_timer.sv
// sweep_timer: sweep period divider; counts sweep ticks down and flags the tick
// that brings it to zero, reloading itself on that tick. A period of 0 counts
// as the longest period (2**PERIOD_W ticks).
module sweep_timer #(
    parameter int PERIOD_W = 3
) (
    input  logic                clk,
    input  logic                apu_reset,
    input  logic                i_load,
    input  logic [PERIOD_W-1:0] i_period,
    input  logic                i_tick,
    output logic                o_zero
);

    localparam logic [PERIOD_W:0] ONE_COUNT = {{PERIOD_W{1'b0}}, 1'b1};
    localparam logic [PERIOD_W:0] MAX_COUNT = {1'b1, {PERIOD_W{1'b0}}};

    logic [PERIOD_W:0] r_count;
    logic [PERIOD_W:0] w_reload;

    assign w_reload = (i_period == '0) ? MAX_COUNT : {1'b0, i_period};
    assign o_zero   = i_tick && (r_count <= ONE_COUNT);

    // Count ticks down; load on trigger, reload when the count reaches zero.
    always_ff @(posedge clk or posedge apu_reset) begin
        if (apu_reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= w_reload;
        end else if (i_tick) begin
            if (o_zero) begin
                r_count <= w_reload;
            end else begin
                r_count <= r_count - ONE_COUNT;
            end
        end
    end

endmodule

// File: rtl/freq_sweep.sv
// freq_sweep: APU square-channel frequency sweep unit. A shift/add calculation
// FSM computes shadow +/- (shadow >> shift), commits it on period expiry and
// disables the channel on overflow.
// Optional build macro FREQ_SWEEP_NEG_QUIRK_EN: after a negate-mode calculation
// since the last trigger, a config write clearing negate disables the channel.
module freq_sweep
    import apu_pkg::*;
#(
    parameter int FREQ_W   = DEF_FREQ_W,
    parameter int SHIFT_W  = DEF_SHIFT_W,
    parameter int PERIOD_W = DEF_PERIOD_W
) (
    input  logic                clk,
    input  logic                apu_reset,
    input  logic                cfg_wr,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                cfg_negate,
    input  logic [SHIFT_W-1:0]  cfg_shift,
    input  logic                freq_wr,
    input  logic [FREQ_W-1:0]   freq_d,
    input  logic                trigger,
    input  logic                sweep_tick,
    output logic                cfg_negate_q,
    output logic [FREQ_W-1:0]   freq,
    output logic                ch_off,
    output logic                busy
);

    localparam logic [SHIFT_W-1:0] ONE_SHIFT = {{(SHIFT_W-1){1'b0}}, 1'b1};

    logic [PERIOD_W-1:0] r_cfgPeriod;
    logic                r_cfgNegate;
    logic [SHIFT_W-1:0]  r_cfgShift;
    logic [FREQ_W-1:0]   r_freq;
    logic [FREQ_W-1:0]   r_shadow;
    logic [FREQ_W-1:0]   r_operand;
    logic [SHIFT_W-1:0]  r_cnt;
    logic [SHIFT_W-1:0]  r_calcShift;
    logic                r_calcNeg;
    logic                r_isUpdate;
    logic                r_sweepEn;
    logic                r_pending;
    logic                r_chOff;
    sweep_state_t        r_state;
`ifdef FREQ_SWEEP_NEG_QUIRK_EN
    logic                r_negUsed;
`endif

    logic                w_trigEn;
    logic                w_serve;
    logic                w_expire;
    logic                w_startUpdate;
    logic [FREQ_W:0]     w_sum;
    logic                w_ovf;

    assign w_trigEn      = (r_cfgPeriod != '0) || (r_cfgShift != '0);
    assign w_serve       = (r_state == ST_IDLE) && !trigger && r_sweepEn && (r_pending || sweep_tick);
    assign w_startUpdate = w_serve && w_expire && (r_cfgPeriod != '0);
    assign w_sum         = r_calcNeg ? ({1'b0, r_shadow} - {1'b0, r_operand})
                                     : ({1'b0, r_shadow} + {1'b0, r_operand});
    assign w_ovf         = !r_calcNeg && w_sum[FREQ_W];

    assign cfg_negate_q = r_cfgNegate;
    assign freq         = r_freq;
    assign ch_off       = r_chOff;
    assign busy         = (r_state != ST_IDLE);

    sweep_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk       (clk),
        .apu_reset (apu_reset),
        .i_load    (trigger),
        .i_period  (r_cfgPeriod),
        .i_tick    (w_serve),
        .o_zero    (w_expire)
    );

    // Latch the sweep configuration fields; a running calculation keeps its own snapshot.
    always_ff @(posedge clk or posedge apu_reset) begin
        if (apu_reset) begin
            r_cfgPeriod <= '0;
            r_cfgNegate <= 1'b0;
            r_cfgShift  <= '0;
        end else if (cfg_wr) begin
            r_cfgPeriod <= cfg_period;
            r_cfgNegate <= cfg_negate;
            r_cfgShift  <= cfg_shift;
        end
    end

    // Trigger handling, tick arbitration and the shift/sum/commit calculation FSM.
    always_ff @(posedge clk or posedge apu_reset) begin
        if (apu_reset) begin
            r_freq      <= '0;
            r_shadow    <= '0;
            r_operand   <= '0;
            r_cnt       <= '0;
            r_calcShift <= '0;
            r_calcNeg   <= 1'b0;
            r_isUpdate  <= 1'b0;
            r_sweepEn   <= 1'b0;
            r_pending   <= 1'b0;
            r_chOff     <= 1'b0;
            r_state     <= ST_IDLE;
`ifdef FREQ_SWEEP_NEG_QUIRK_EN
            r_negUsed   <= 1'b0;
`endif
        end else begin
            r_chOff <= 1'b0;
            if (trigger) begin
                r_shadow  <= r_freq;
                r_sweepEn <= w_trigEn;
                r_pending <= sweep_tick && w_trigEn;
`ifdef FREQ_SWEEP_NEG_QUIRK_EN
                r_negUsed <= (r_cfgShift != '0) && r_cfgNegate;
`endif
                if (r_cfgShift != '0) begin
                    r_operand   <= r_freq;
                    r_cnt       <= r_cfgShift;
                    r_calcShift <= r_cfgShift;
                    r_calcNeg   <= r_cfgNegate;
                    r_isUpdate  <= 1'b0;
                    r_state     <= ST_SHIFT;
                end else begin
                    r_state <= ST_IDLE;
                end
            end else begin
                if ((r_state != ST_IDLE) && sweep_tick && r_sweepEn) begin
                    r_pending <= 1'b1;
                end
                case (r_state)
                    ST_IDLE: begin
                        r_pending <= 1'b0;
                        if (w_startUpdate) begin
                            r_operand   <= r_shadow;
                            r_cnt       <= r_cfgShift;
                            r_calcShift <= r_cfgShift;
                            r_calcNeg   <= r_cfgNegate;
                            r_isUpdate  <= 1'b1;
                            r_state     <= (r_cfgShift == '0) ? ST_SUM : ST_SHIFT;
`ifdef FREQ_SWEEP_NEG_QUIRK_EN
                            if (r_cfgNegate) begin
                                r_negUsed <= 1'b1;
                            end
`endif
                        end
                    end
                    ST_SHIFT: begin
                        r_operand <= r_operand >> 1;
                        r_cnt     <= r_cnt - ONE_SHIFT;
                        if (r_cnt == ONE_SHIFT) begin
                            r_state <= ST_SUM;
                        end
                    end
                    ST_SUM: begin
                        if (w_ovf) begin
                            r_chOff   <= 1'b1;
                            r_sweepEn <= 1'b0;
                            r_state   <= ST_IDLE;
                        end else if (r_isUpdate && (r_calcShift != '0)) begin
                            r_freq   <= w_sum[FREQ_W-1:0];
                            r_shadow <= w_sum[FREQ_W-1:0];
                            r_state  <= ST_COMMIT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_COMMIT: begin
                        r_operand  <= r_shadow;
                        r_cnt      <= r_calcShift;
                        r_isUpdate <= 1'b0;
                        r_state    <= ST_SHIFT;
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
            if (freq_wr) begin
                r_freq <= freq_d;
            end
`ifdef FREQ_SWEEP_NEG_QUIRK_EN
            if (cfg_wr && !cfg_negate && r_negUsed) begin
                r_chOff   <= 1'b1;
                r_sweepEn <= 1'b0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_freq_sweep.sv
// tb_freq_sweep: directed self-checking bench for freq_sweep with hand-computed
// expected frequencies, pulse timing and reset behaviour.
module tb_freq_sweep;

    logic        clk;
    logic        apu_reset;
    logic        cfg_wr;
    logic [2:0]  cfg_period;
    logic        cfg_negate;
    logic [2:0]  cfg_shift;
    logic        freq_wr;
    logic [10:0] freq_d;
    logic        trigger;
    logic        sweep_tick;
    logic        cfg_negate_q;
    logic [10:0] freq;
    logic        ch_off;
    logic        busy;

    int checkCount = 0;
    int errorCount = 0;

`ifdef FREQ_SWEEP_NEG_QUIRK_EN
    localparam logic [31:0] EXP_QUIRK_PULSE = 32'd1;
    localparam logic [31:0] EXP_AFTER_QUIRK = 32'h200;
`else
    localparam logic [31:0] EXP_QUIRK_PULSE = 32'd0;
    localparam logic [31:0] EXP_AFTER_QUIRK = 32'h300;
`endif

    freq_sweep dut (
        .clk          (clk),
        .apu_reset    (apu_reset),
        .cfg_wr       (cfg_wr),
        .cfg_period   (cfg_period),
        .cfg_negate   (cfg_negate),
        .cfg_shift    (cfg_shift),
        .freq_wr      (freq_wr),
        .freq_d       (freq_d),
        .trigger      (trigger),
        .sweep_tick   (sweep_tick),
        .cfg_negate_q (cfg_negate_q),
        .freq         (freq),
        .ch_off       (ch_off),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something stalls outside the bounded waits.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic writeCfg(input logic [2:0] period, input logic negate, input logic [2:0] shift);
        @(negedge clk);
        cfg_wr     = 1'b1;
        cfg_period = period;
        cfg_negate = negate;
        cfg_shift  = shift;
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic writeFreq(input logic [10:0] value);
        @(negedge clk);
        freq_wr = 1'b1;
        freq_d  = value;
        @(negedge clk);
        freq_wr = 1'b0;
    endtask

    task automatic pulseTrigger();
        @(negedge clk);
        trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
    endtask

    task automatic pulseTick();
        @(negedge clk);
        sweep_tick = 1'b1;
        @(negedge clk);
        sweep_tick = 1'b0;
    endtask

    task automatic waitIdle(input int maxCycles, output int chOffSeen);
        int n;
        chOffSeen = 0;
        n = 0;
        while (busy && n < maxCycles) begin
            @(negedge clk);
            n++;
            if (ch_off) chOffSeen++;
        end
        if (busy) checkOutput("idle_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        int seen;
        logic [31:0] expTable [6];
        expTable = '{32'h100, 32'h100, 32'h180, 32'h180, 32'h180, 32'h240};

        apu_reset  = 1'b1;
        cfg_wr     = 1'b0;
        cfg_period = '0;
        cfg_negate = 1'b0;
        cfg_shift  = '0;
        freq_wr    = 1'b0;
        freq_d     = '0;
        trigger    = 1'b0;
        sweep_tick = 1'b0;

        idleCycles(3);
        checkOutput("reset_freq", 32'(freq), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_choff", 32'(ch_off), 32'd0);
        checkOutput("reset_negq", 32'(cfg_negate_q), 32'd0);
        apu_reset = 1'b0;
        idleCycles(1);

        // Overflow in the check-only pass after trigger
        writeCfg(3'd0, 1'b0, 3'd1);
        writeFreq(11'h700);
        checkOutput("freq_write", 32'(freq), 32'h700);
        pulseTrigger();
        checkOutput("ovf_busy_start", 32'(busy), 32'd1);
        checkOutput("ovf_no_early_pulse", 32'(ch_off), 32'd0);
        idleCycles(1);
        checkOutput("ovf_pulse_not_yet", 32'(ch_off), 32'd0);
        idleCycles(1);
        checkOutput("ovf_pulse", 32'(ch_off), 32'd1);
        checkOutput("ovf_idle", 32'(busy), 32'd0);
        idleCycles(1);
        checkOutput("ovf_pulse_end", 32'(ch_off), 32'd0);
        checkOutput("ovf_freq_kept", 32'(freq), 32'h700);

        // Add mode update with check pass, then update-pass overflow
        writeCfg(3'd1, 1'b0, 3'd2);
        writeFreq(11'h400);
        pulseTrigger();
        waitIdle(20, seen);
        checkOutput("add_trig_nochoff", 32'(seen), 32'd0);
        checkOutput("add_trig_freq", 32'(freq), 32'h400);
        pulseTick();
        checkOutput("add_tick_busy", 32'(busy), 32'd1);
        idleCycles(2);
        checkOutput("add_before_commit", 32'(freq), 32'h400);
        idleCycles(1);
        checkOutput("add_commit", 32'(freq), 32'h500);
        checkOutput("add_commit_busy", 32'(busy), 32'd1);
        waitIdle(20, seen);
        checkOutput("add_check_nochoff", 32'(seen), 32'd0);
        pulseTick();
        waitIdle(20, seen);
        checkOutput("add_tick2_freq", 32'(freq), 32'h640);
        checkOutput("add_tick2_nochoff", 32'(seen), 32'd0);
        pulseTick();
        waitIdle(20, seen);
        checkOutput("add_tick3_freq", 32'(freq), 32'h7D0);
        checkOutput("add_tick3_choff", 32'(seen), 32'd1);
        pulseTick();
        checkOutput("disabled_tick_busy", 32'(busy), 32'd0);
        waitIdle(20, seen);
        checkOutput("disabled_tick_freq", 32'(freq), 32'h7D0);

        // Negate mode update, then a config write clearing negate
        writeCfg(3'd1, 1'b1, 3'd1);
        checkOutput("negq_set", 32'(cfg_negate_q), 32'd1);
        writeFreq(11'h400);
        pulseTrigger();
        waitIdle(20, seen);
        pulseTick();
        waitIdle(20, seen);
        checkOutput("neg_freq", 32'(freq), 32'h200);
        checkOutput("neg_nochoff", 32'(seen), 32'd0);
        writeCfg(3'd1, 1'b0, 3'd1);
        checkOutput("quirk_pulse", 32'(ch_off), EXP_QUIRK_PULSE);
        pulseTick();
        waitIdle(20, seen);
        checkOutput("quirk_after_tick", 32'(freq), EXP_AFTER_QUIRK);

        // Period 3: updates only on every third tick
        writeCfg(3'd3, 1'b0, 3'd1);
        writeFreq(11'h100);
        pulseTrigger();
        waitIdle(20, seen);
        for (int i = 0; i < 6; i++) begin
            pulseTick();
            waitIdle(20, seen);
            checkOutput($sformatf("period3_tick%0d", i + 1), 32'(freq), expTable[i]);
        end

        // Tick arriving while busy is held and served on the first idle cycle
        writeCfg(3'd1, 1'b0, 3'd2);
        writeFreq(11'h100);
        pulseTrigger();
        pulseTick();
        waitIdle(20, seen);
        checkOutput("pending_not_yet", 32'(freq), 32'h100);
        idleCycles(1);
        checkOutput("pending_served", 32'(busy), 32'd1);
        waitIdle(20, seen);
        checkOutput("pending_freq", 32'(freq), 32'h140);

        // Trigger during an update calculation aborts it without committing
        writeFreq(11'h400);
        pulseTrigger();
        waitIdle(20, seen);
        pulseTick();
        pulseTrigger();
        waitIdle(20, seen);
        checkOutput("abort_no_commit", 32'(freq), 32'h400);

        // Reset asserted in the middle of SHIFT
        writeCfg(3'd1, 1'b0, 3'd3);
        writeFreq(11'h200);
        pulseTrigger();
        idleCycles(1);
        checkOutput("mid_shift_busy", 32'(busy), 32'd1);
        apu_reset = 1'b1;
        #1;
        checkOutput("rst_mid_freq", 32'(freq), 32'h0);
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        idleCycles(2);
        apu_reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ch_off) seen++;
        end
        checkOutput("rst_mid_nochoff", 32'(seen), 32'd0);
        checkOutput("rst_mid_freq_after", 32'(freq), 32'h0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/freq_sweep.md
FREQ_SWEEP -- requirements
Module: freq_sweep

Interface
REQ-001 SHALL have parameter FREQ_W, default 11: width of the frequency register and the shadow register.
REQ-002 SHALL have parameter SHIFT_W, default 3: width of the sweep shift-count field.
REQ-003 SHALL have parameter PERIOD_W, default 3: width of the sweep period field.
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port apu_reset, input, 1: asynchronous reset, active-high.
REQ-006 SHALL have ports cfg_wr (in, 1), cfg_period (in, PERIOD_W), cfg_negate (in, 1) and cfg_shift (in, SHIFT_W): a sweep-config write strobe and its fields.
REQ-007 SHALL have ports freq_wr (in, 1) and freq_d (in, FREQ_W): a CPU frequency write strobe and its data.
REQ-008 SHALL have ports trigger (in, 1), sweep_tick (in, 1) and cfg_negate_q (out, 1): channel trigger, the 128 Hz one-cycle strobe, and the stored negate bit.
REQ-009 SHALL have ports freq (out, FREQ_W), ch_off (out, 1) and busy (out, 1): current frequency, overflow channel-disable pulse, and calculation in progress.

Function
REQ-010 SHALL latch the cfg_* fields into registers on cfg_wr; a cfg_wr that occurs during a calculation takes effect from the next calculation.
REQ-011 SHALL load freq from freq_d on freq_wr and leave the shadow register unchanged; if freq_wr coincides with a commit, freq_wr wins.
REQ-012 SHALL, on trigger: shadow <= freq; timer <= period, with period 0 loaded as 2**PERIOD_W; sweep_en <= (period!=0 || shift!=0); and, if shift!=0, start a check-only calculation.
REQ-013 SHALL, on each sweep_tick with sweep_en=1, decrement timer; on reaching 0 it reloads timer and, if period!=0, starts an update calculation.
REQ-014 SHALL use a calculation FSM with states IDLE -> SHIFT -> SUM -> (COMMIT | IDLE).
REQ-015 SHALL, in SHIFT, shift a copy of shadow right by one bit per cycle for exactly `shift` cycles; shift=0 passes through in zero cycles.
REQ-016 SHALL, in SUM, compute the FREQ_W+1-bit value shadow + operand (negate=0) or shadow - operand (negate=1), and set ovf = bit FREQ_W in add mode; subtract never overflows.
REQ-017 SHALL, if ovf=1, pulse ch_off for one cycle, clear sweep_en and return to IDLE.
REQ-018 SHALL, for an update calculation with ovf=0 and shift!=0, use COMMIT to write the result to freq and shadow and then re-enter SHIFT as a check-only pass; the second pass raises ch_off only and never commits.
REQ-019 SHALL NOT change freq or shadow in a check-only pass or when shift=0.
REQ-020 SHALL drive busy=1 in every state except IDLE; latency from start to ch_off or commit is shift+1 cycles.
REQ-021 SHALL handle a trigger during busy by aborting the current calculation and restarting it per REQ-012, discarding the partial result.
REQ-022 SHALL hold one pending flag when sweep_tick arrives while busy; the pending tick is served on the first IDLE cycle, and further ticks are dropped until it is served.
REQ-023 SHALL process a trigger before a sweep_tick when both occur in the same cycle.

Reset
REQ-024 SHALL, while apu_reset=1, asynchronously clear freq, shadow, timer, cfg registers, sweep_en, the pending flag, ch_off and busy to 0 and place the FSM in IDLE, aborting any calculation in progress.

Configuration
REQ-025 SHALL, with FREQ_SWEEP_NEG_QUIRK_EN defined, record that a negate-mode calculation has run since trigger; a cfg_wr then clearing negate pulses ch_off and clears sweep_en.
REQ-026 SHALL, without FREQ_SWEEP_NEG_QUIRK_EN, treat negate changes like any other config write with no side effect.

Structure
REQ-027 SHALL place the FSM state enum and default widths (FREQ_W=11, SHIFT_W=3, PERIOD_W=3) in shared package apu_pkg.
REQ-028 SHALL implement the period counter as sub-module sweep_timer: load, tick, zero output, period-0 mapped to max.

Verification
REQ-029 SHALL cover: freq=0x700, shift=1, add, trigger -> ch_off pulse 2 cycles later (0x700+0x380=0xA80 > 0x7FF), freq stays 0x700.
REQ-030 SHALL cover: freq=0x400, period=1, shift=2, add, trigger then tick -> freq=0x500, check pass 0x640 raises no ch_off.
REQ-031 SHALL cover: freq=0x400, shift=1, negate, period=1, tick -> freq=0x200, no ch_off.
REQ-032 SHALL cover: period=3, shift=1, freq=0x100, ticks 1..6 -> freq changes only after ticks 3 and 6 (0x180, then 0x240).
REQ-033 SHALL cover: tick during busy -> served after IDLE; apu_reset mid-SHIFT -> freq=0, busy=0, no ch_off.
REQ-034 SHALL cover: with FREQ_SWEEP_NEG_QUIRK_EN, negate calculation then cfg_wr with negate=0 -> ch_off pulse; without the macro -> no pulse.
